// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state
// encoding, legal WIDTH range and the counter-width helper.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 32;

  // Bit counter must hold 0..WIDTH-1; never narrower than one bit.
  function automatic int count_width(input int width);
    int w;
    w = $clog2(width + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle between the requester and the serial adder.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_add_ctrl_full_add.sv
// One-bit adder cells: half adder, and a full adder built from two half
// adders with the carries ORed (they can never both be set).
module half_add (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b;
  assign carry = a & b;
endmodule

module full_add (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  logic s0;
  logic c0;
  logic c1;

  half_add u_ha0 (.a(a),  .b(b),   .sum(s0),  .carry(c0));
  half_add u_ha1 (.a(s0), .b(cin), .sum(sum), .carry(c1));

  assign cout = c0 | c1;
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: captures operands on start, runs one full
// adder cell over them LSB first for WIDTH cycles, then publishes the
// registered {cout,sum} together with a one-cycle done pulse.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  serial_add_ctrl_if.slave bus
);

  localparam int CNT_W = count_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] ps;
  logic [WIDTH-1:0] ps_next;
  logic [WIDTH-1:0] sum_r;
  logic [CNT_W-1:0] count;
  logic             carry;
  logic             cout_r;
  logic             fa_sum;
  logic             fa_cout;

  // The single iterated datapath cell, fed from the operand LSBs.
  full_add u_fa (
    .a    (ra[0]),
    .b    (rb[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // New sum bit enters at the MSB; written as shifts so WIDTH=1 works.
  always_comb begin
    ps_next = (ps >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
  end

  // Controller FSM with counter, shift registers and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ra     <= '0;
      rb     <= '0;
      ps     <= '0;
      carry  <= 1'b0;
      count  <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            ra    <= bus.a;
            rb    <= bus.b;
            carry <= bus.cin;
            ps    <= '0;
            count <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          ra    <= ra >> 1;
          rb    <= rb >> 1;
          ps    <= ps_next;
          carry <= fa_cout;
          count <= count + CNT_W'(1);
          if (count == LAST) begin
            sum_r  <= ps_next;
            cout_r <= fa_cout;
            state  <= DONE;
          end
        end
        DONE: begin
          // Requests arriving here are dropped, not queued.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Status decoded from registered state only; no path from start.
  assign bus.busy = (state == SHIFT);
  assign bus.done = (state == DONE);
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder controller that sequences a single one-bit full-adder cell over two WIDTH-bit operands, one bit per clock, LSB first. It captures operands on a start request, iterates the full adder WIDTH times while holding the carry in a register, then presents the registered sum and carry-out with a one-cycle done pulse. It sits beside the combinational adder cells as their sequencer, trading area for WIDTH+1 cycles of latency.

## Interface
- WIDTH, 8, operand/sum width in bits; legal range 1..32.

- clk  input  1  rising-edge clock, sole clock domain
- rst  input  1  synchronous, active-high reset
- start  input  1  request; accepted only in IDLE
- a  input  WIDTH  operand A, sampled on the accepting edge
- b  input  WIDTH  operand B, sampled on the accepting edge
- cin  input  1  carry-in, sampled on the accepting edge
- busy  output  1  high while in SHIFT
- done  output  1  one-cycle pulse; sum/cout valid from this cycle
- sum  output  WIDTH  registered result, held until next completion
- cout  output  1  registered carry-out, held with sum

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: busy=0, done=0. If start=1 at an edge: load shift registers ra<=a, rb<=b, carry<=cin, partial sum register ps<=0, count<=0; go to SHIFT.
- SHIFT: each edge feeds ra[0], rb[0], carry into the full adder; s bit shifts into ps at MSB (ps<={s, ps[WIDTH-1:1]}); ra, rb shift right by one; carry<=carry-out; count<=count+1. On the edge where count==WIDTH-1: sum<={s, ps[WIDTH-1:1]}, cout<=carry-out; go to DONE.
- DONE: done=1, busy=0 for exactly one cycle; unconditionally go to IDLE on next edge. start in DONE is ignored (not queued).
- start while in SHIFT or DONE is ignored; a, b, cin are don't-care outside the accepting edge.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); no overflow flag.
- count is $clog2(WIDTH+1) bits wide (min 1); never exceeds WIDTH-1 in SHIFT.
- sum/cout change only on the completion edge or on reset; never show partial results.

## Timing
- Reset (rst=1 at an edge, any state, including mid-SHIFT): state<=IDLE, busy=0, done=0, sum=0, cout=0, internal registers cleared; in-flight operation discarded, no done pulse. rst takes priority over start.
- Start accepted at edge k: busy=1 from after edge k through edge k+WIDTH; done=1 in the cycle after edge k+WIDTH; back in IDLE after edge k+WIDTH+1.
- Earliest next accept: edge k+WIDTH+2 (start high in IDLE); throughput one result per WIDTH+2 cycles.
- WIDTH=1: single SHIFT cycle; done in cycle after edge k+1.
- Outputs busy and done are decoded from the registered state only (no combinational path from start).

## Structure
- Shared package serial_add_pkg: state encoding constants (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2), and WIDTH legal range limits.
- One sub-module: full_add (one-bit full adder, sum/carry, composed of two half_add instances plus OR of carries), instantiated once as the iterated datapath cell.
- Controller FSM, counter, shift registers and result registers live in serial_add_ctrl.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, cin=0 -> done exactly 9 cycles after the accepting edge, sum=0x96, cout=0; busy high for 8 cycles.
- WIDTH=8, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- start held high continuously from IDLE -> accepts every WIDTH+2 cycles; start pulses during SHIFT/DONE with different operands -> no effect on running result.
- rst asserted at 4th SHIFT cycle -> next cycle IDLE, busy=0, done=0, sum=0, cout=0; no done pulse; fresh start afterwards gives correct result.
- WIDTH=1 exhaustive over a, b, cin (8 cases) -> {cout,sum}=a+b+cin, done 2 cycles after accept.
- WIDTH=8 random 1000 operations vs. reference a+b+cin -> all match; sum/cout stable between done pulses.
